hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Producer side of the ID stage's `freeze` interface.
- Tracks destination registers of in-flight instructions in EXE, MEM and WB, using an internal 3-slot shift register that mirrors the pipeline registers.
- Compares them against the sources being decoded in ID, and generates:
  - `freeze` (ID bubble insertion, IF/PC hold);
  - `flush` on taken branch;
  - forwarding selects for EXE;
  - a stall counter.

Parameters:
- FORWARD_EN, 1, 1 = forwarding present (stall only on load-use); 0 = stall on any RAW hit in EXE or MEM.
- WB_BYPASS, 1, 1 = register file is write-before-read, so a WB-slot match is not a hazard; 0 = a WB-slot match also stalls when FORWARD_EN=0.
- CNT_W, 32, width of stall_count.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-low reset
- id_src1  in  5  ID source register 1 (instr[25:21])
- id_src2  in  5  ID hazard source 2 (0 for immediate-type)
- id_dst  in  5  ID destination register
- id_wb_en  in  1  ID write-back enable, pre-bubble
- id_mem_r_en  in  1  ID load flag, pre-bubble
- br_taken  in  1  taken branch resolved in EXE this cycle
- ext_stall  in  1  memory-busy stall; whole pipeline holds
- freeze  out  1  to ID mux select and IF PC hold
- flush  out  1  clear IF/ID register
- fwd_a  out  2  EXE operand A select: 00 reg file, 01 MEM result, 10 WB result
- fwd_b  out  2  EXE operand B select, same encoding
- stall_count  out  CNT_W  cycles in which freeze was asserted

Behaviour:
- Slots:
  - EXE, MEM and WB each hold {dst[4:0], wb_en, mem_r_en}.
  - A slot is valid for hazard purposes only when wb_en=1 and dst!=0.
  - Register 0 never causes a hazard or a forward.
- Match definition: `hit_X_s` = slot X valid and slot X dst == id_srcN, for N = 1, 2.
- Raw hazard (combinational):
  - FORWARD_EN=1: haz = (hit_EXE_1 | hit_EXE_2) & EXE.mem_r_en.
  - FORWARD_EN=0: haz = any hit in EXE or MEM; WB hits are added when WB_BYPASS=0.
- Outputs:
  - freeze = haz & ~br_taken & rst. Wrong-path instructions never stall.
  - flush = br_taken & rst.
- Slot update, every rising edge while rst=1 and ext_stall=0:
  - WB <= MEM, MEM <= EXE.
  - EXE <= bubble (all zero) if freeze or br_taken; otherwise EXE <= {id_dst, id_wb_en, id_mem_r_en}.
- ext_stall=1: all slots hold, stall_count holds, freeze still evaluated combinationally. ext_stall has priority over the slot update.
- Forwarding (FORWARD_EN=1, combinational, from the EXE-stage instruction's sources):
  - Sources are latched into internal ex_src1/ex_src2 on the same enable as the EXE slot; they are zeroed on bubble.
  - fwd_a = 01 if MEM slot valid and MEM.dst == ex_src1; else 10 if WB slot valid and WB.dst == ex_src1; else 00. MEM has priority.
  - fwd_b is the same using ex_src2.
  - FORWARD_EN=0: fwd_a = fwd_b = 00 constantly.
- stall_count: increments by 1 on each edge where freeze=1 and ext_stall=0. It wraps from all-ones to 0.
- Reset (rst=0 at an edge):
  - All slots and ex_src registers are cleared to 0; stall_count = 0.
  - freeze, flush = 0 and fwd = 00 while rst=0.
  - Reset mid-stall discards pending hazards; the first cycle after reset never freezes.
- Simultaneous br_taken and haz: flush=1, freeze=0, and a single bubble enters EXE.
- Latency:
  - freeze and flush have 0-cycle latency from inputs.
  - Slot contents reflect ID inputs one edge later.
  - A load-use stall lasts exactly 1 cycle.
  - A non-forwarding RAW stall lasts at most 2 cycles (3 cycles with WB_BYPASS=0).

Test Plan:
1. Reset: rst=0 for 2 cycles with id_src1=5 and a prior EXE slot writing r5 -> freeze=0, fwd_a=00, stall_count=0; first cycle after release freeze=0.
2. Load-use (FORWARD_EN=1): LW r3 in ID (dst=3, wb_en=1, mem_r_en=1), next cycle ADD src1=3 -> freeze=1 for exactly 1 cycle, stall_count=1; following cycle fwd_a=10 (WB forward after the bubble).
3. ALU forward (FORWARD_EN=1): ADD r4 then SUB src2=4 -> freeze never asserted; when SUB is in EXE, fwd_b=01. With an intervening independent instruction -> fwd_b=10.
4. No-forward RAW (FORWARD_EN=0, WB_BYPASS=1): ADD r7 then OR src1=7 -> freeze=1 for 2 consecutive cycles, stall_count=2, then released.
5. r0 and immediate: producer dst=0 with wb_en=1, consumer src1=0, src2=0 -> freeze=0, fwd_a=fwd_b=00.
6. Branch vs hazard: load-use condition present with br_taken=1 in the same cycle -> flush=1, freeze=0, EXE slot bubble. Then ext_stall=1 for 3 cycles -> slots and stall_count frozen; values unchanged after release.

Source files
------------

// File: rtl/hazard_scoreboard_if.sv
// ID-stage hazard interface: decode-side sources/destination in,
// freeze/flush/forward selects and stall count out.
interface hazard_scoreboard_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       id_src1;
    logic [4:0]       id_src2;
    logic [4:0]       id_dst;
    logic             id_wb_en;
    logic             id_mem_r_en;
    logic             br_taken;
    logic             ext_stall;
    logic             freeze;
    logic             flush;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output id_src1, id_src2, id_dst, id_wb_en, id_mem_r_en,
        output br_taken, ext_stall,
        input  freeze, flush, fwd_a, fwd_b, stall_count
    );

    modport slave (
        input  id_src1, id_src2, id_dst, id_wb_en, id_mem_r_en,
        input  br_taken, ext_stall,
        output freeze, flush, fwd_a, fwd_b, stall_count
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Tracks EXE/MEM/WB destinations against ID sources; drives freeze,
// flush, EXE forwarding selects and a freeze-cycle counter.
module hazard_scoreboard #(
    parameter bit FORWARD_EN = 1'b1,
    parameter bit WB_BYPASS  = 1'b1,
    parameter int CNT_W      = 32
) (
    input logic              clk,
    input logic              rst,
    hazard_scoreboard_if.slave bus
);
    typedef struct packed {
        logic [4:0] dst;
        logic       wb_en;
        logic       mem_r_en;
    } slot_t;

    slot_t            r_exe;
    logic [4:0]       r_mem_dst;
    logic             r_mem_wb;
    logic [4:0]       r_wb_dst;
    logic             r_wb_wb;
    logic [4:0]       r_ex_src1;
    logic [4:0]       r_ex_src2;
    logic [CNT_W-1:0] r_stall_cnt;

    logic       w_exe_v;
    logic       w_mem_v;
    logic       w_wb_v;
    logic       w_hit_exe;
    logic       w_hit_mem;
    logic       w_hit_wb;
    logic       w_haz;
    logic       w_freeze;
    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;

    // dst!=0 in validity keeps r0 out of every match
    assign w_exe_v = r_exe.wb_en && (r_exe.dst != 5'd0);
    assign w_mem_v = r_mem_wb && (r_mem_dst != 5'd0);
    assign w_wb_v  = r_wb_wb && (r_wb_dst != 5'd0);

    assign w_hit_exe = w_exe_v &&
        ((r_exe.dst == bus.id_src1) || (r_exe.dst == bus.id_src2));
    assign w_hit_mem = w_mem_v &&
        ((r_mem_dst == bus.id_src1) || (r_mem_dst == bus.id_src2));
    assign w_hit_wb = w_wb_v &&
        ((r_wb_dst == bus.id_src1) || (r_wb_dst == bus.id_src2));

    assign w_haz = FORWARD_EN ?
        (w_hit_exe && r_exe.mem_r_en) :
        (w_hit_exe || w_hit_mem || (!WB_BYPASS && w_hit_wb));

    assign w_freeze = w_haz && !bus.br_taken && rst;

    always_comb begin
        w_fwd_a = 2'b00;
        w_fwd_b = 2'b00;
        if (FORWARD_EN && rst) begin
            if (w_mem_v && (r_mem_dst == r_ex_src1)) w_fwd_a = 2'b01;
            else if (w_wb_v && (r_wb_dst == r_ex_src1)) w_fwd_a = 2'b10;
            if (w_mem_v && (r_mem_dst == r_ex_src2)) w_fwd_b = 2'b01;
            else if (w_wb_v && (r_wb_dst == r_ex_src2)) w_fwd_b = 2'b10;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_exe       <= '0;
            r_mem_dst   <= 5'd0;
            r_mem_wb    <= 1'b0;
            r_wb_dst    <= 5'd0;
            r_wb_wb     <= 1'b0;
            r_ex_src1   <= 5'd0;
            r_ex_src2   <= 5'd0;
            r_stall_cnt <= '0;
        end else if (!bus.ext_stall) begin
            r_wb_dst  <= r_mem_dst;
            r_wb_wb   <= r_mem_wb;
            r_mem_dst <= r_exe.dst;
            r_mem_wb  <= r_exe.wb_en;
            // a frozen or wrong-path ID instruction becomes a bubble
            if (w_freeze || bus.br_taken) begin
                r_exe     <= '0;
                r_ex_src1 <= 5'd0;
                r_ex_src2 <= 5'd0;
            end else begin
                r_exe     <= {bus.id_dst, bus.id_wb_en, bus.id_mem_r_en};
                r_ex_src1 <= bus.id_src1;
                r_ex_src2 <= bus.id_src2;
            end
            if (w_freeze)
                r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign bus.freeze      = w_freeze;
    assign bus.flush       = bus.br_taken && rst;
    assign bus.fwd_a       = w_fwd_a;
    assign bus.fwd_b       = w_fwd_b;
    assign bus.stall_count = r_stall_cnt;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench: three configurations driven in lockstep, checked against an
// instruction-level pipeline model.
module tb_hazard_scoreboard;
    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    hazard_scoreboard_if #(.CNT_W(32)) if_a ();
    hazard_scoreboard_if #(.CNT_W(32)) if_b ();
    hazard_scoreboard_if #(.CNT_W(3))  if_c ();

    hazard_scoreboard #(.FORWARD_EN(1'b1), .WB_BYPASS(1'b1), .CNT_W(32))
        dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
    hazard_scoreboard #(.FORWARD_EN(1'b0), .WB_BYPASS(1'b1), .CNT_W(32))
        dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));
    hazard_scoreboard #(.FORWARD_EN(1'b0), .WB_BYPASS(1'b0), .CNT_W(3))
        dut_c (.clk(clk), .rst(rst), .bus(if_c.slave));

    typedef struct {
        int dst;
        bit wb;
        bit mr;
        int s1;
        int s2;
    } ins_t;

    ins_t        pipe [3][3];
    int unsigned cnt  [3];
    int          n_checks;
    int          n_pass;
    int          n_fail;
    int          c_s1;
    int          c_s2;
    bit          c_br;
    bit          c_rst;

    function automatic bit fe(int c);
        return c == 0;
    endfunction

    function automatic bit wbb(int c);
        return c != 2;
    endfunction

    function automatic int unsigned cmask(int c);
        return (c == 2) ? 32'd7 : 32'hFFFF_FFFF;
    endfunction

    function automatic bit writes(ins_t e, int s);
        return e.wb && e.dst != 0 && e.dst == s;
    endfunction

    function automatic bit m_haz(int c);
        bit h;
        h = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bit hit;
            hit = writes(pipe[c][k], c_s1) || writes(pipe[c][k], c_s2);
            if (fe(c)) begin
                if (k == 0 && hit && pipe[c][0].mr) h = 1'b1;
            end else if (hit && (k < 2 || !wbb(c))) begin
                h = 1'b1;
            end
        end
        return h;
    endfunction

    function automatic bit m_freeze(int c);
        return c_rst && !c_br && m_haz(c);
    endfunction

    function automatic int m_fwd(int c, int s);
        if (!fe(c) || !c_rst) return 0;
        if (writes(pipe[c][1], s)) return 1;
        if (writes(pipe[c][2], s)) return 2;
        return 0;
    endfunction

    function automatic logic [31:0] obs(int c, int w);
        logic [31:0] v;
        v = '0;
        case (c)
            0: case (w)
                0: v = {31'd0, if_a.freeze};
                1: v = {31'd0, if_a.flush};
                2: v = {30'd0, if_a.fwd_a};
                3: v = {30'd0, if_a.fwd_b};
                default: v = if_a.stall_count;
            endcase
            1: case (w)
                0: v = {31'd0, if_b.freeze};
                1: v = {31'd0, if_b.flush};
                2: v = {30'd0, if_b.fwd_a};
                3: v = {30'd0, if_b.fwd_b};
                default: v = if_b.stall_count;
            endcase
            default: case (w)
                0: v = {31'd0, if_c.freeze};
                1: v = {31'd0, if_c.flush};
                2: v = {30'd0, if_c.fwd_a};
                3: v = {30'd0, if_c.fwd_b};
                default: v = {29'd0, if_c.stall_count};
            endcase
        endcase
        return v;
    endfunction

    task automatic chk(input string tag, input int c,
                       input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s cfg%0d: got %0h expected %0h", tag, c, got, exp);
        end
    endtask

    task automatic clear_model();
        for (int c = 0; c < 3; c++) begin
            cnt[c] = 0;
            for (int k = 0; k < 3; k++) pipe[c][k] = '{0, 1'b0, 1'b0, 0, 0};
        end
    endtask

    task automatic st(input int s1, input int s2, input int d,
                      input bit wb, input bit mr, input bit br,
                      input bit xs, input bit rn);
        @(negedge clk);
        c_s1 = s1; c_s2 = s2; c_br = br; c_rst = rn;
        rst = rn;
        if_a.id_src1 = 5'(s1); if_b.id_src1 = 5'(s1); if_c.id_src1 = 5'(s1);
        if_a.id_src2 = 5'(s2); if_b.id_src2 = 5'(s2); if_c.id_src2 = 5'(s2);
        if_a.id_dst = 5'(d); if_b.id_dst = 5'(d); if_c.id_dst = 5'(d);
        if_a.id_wb_en = wb; if_b.id_wb_en = wb; if_c.id_wb_en = wb;
        if_a.id_mem_r_en = mr; if_b.id_mem_r_en = mr; if_c.id_mem_r_en = mr;
        if_a.br_taken = br; if_b.br_taken = br; if_c.br_taken = br;
        if_a.ext_stall = xs; if_b.ext_stall = xs; if_c.ext_stall = xs;
        #1;
        for (int c = 0; c < 3; c++) begin
            chk("freeze", c, obs(c, 0), {31'd0, m_freeze(c)});
            chk("flush", c, obs(c, 1), {31'd0, br && rn});
            chk("fwd_a", c, obs(c, 2), 32'(m_fwd(c, pipe[c][0].s1)));
            chk("fwd_b", c, obs(c, 3), 32'(m_fwd(c, pipe[c][0].s2)));
            chk("stall_count", c, obs(c, 4), cnt[c] & cmask(c));
        end
        @(posedge clk);
        for (int c = 0; c < 3; c++) begin
            if (!rn) begin
                cnt[c] = 0;
                for (int k = 0; k < 3; k++)
                    pipe[c][k] = '{0, 1'b0, 1'b0, 0, 0};
            end else if (!xs) begin
                bit fz;
                fz = m_freeze(c);
                if (fz) cnt[c]++;
                pipe[c][2] = pipe[c][1];
                pipe[c][1] = pipe[c][0];
                if (fz || br) pipe[c][0] = '{0, 1'b0, 1'b0, 0, 0};
                else pipe[c][0] = '{d, wb, mr, s1, s2};
            end
        end
    endtask

    initial begin
        n_checks = 0; n_pass = 0; n_fail = 0;
        clear_model();
        rst = 1'b0;
        c_rst = 1'b0; c_br = 1'b0; c_s1 = 0; c_s2 = 0;
        if_a.id_src1 = '0; if_b.id_src1 = '0; if_c.id_src1 = '0;
        if_a.id_src2 = '0; if_b.id_src2 = '0; if_c.id_src2 = '0;
        if_a.id_dst = '0; if_b.id_dst = '0; if_c.id_dst = '0;
        if_a.id_wb_en = 0; if_b.id_wb_en = 0; if_c.id_wb_en = 0;
        if_a.id_mem_r_en = 0; if_b.id_mem_r_en = 0; if_c.id_mem_r_en = 0;
        if_a.br_taken = 0; if_b.br_taken = 0; if_c.br_taken = 0;
        if_a.ext_stall = 0; if_b.ext_stall = 0; if_c.ext_stall = 0;
        repeat (2) @(posedge clk);

        // reset with a pending r5 producer in EXE
        st(0, 0, 5, 1, 1, 0, 0, 1);
        st(5, 0, 0, 0, 0, 0, 0, 0);
        st(5, 0, 0, 0, 0, 0, 0, 0);
        st(5, 0, 0, 0, 0, 0, 0, 1);
        st(0, 0, 0, 0, 0, 0, 0, 1);

        // load-use: LW r3 then ADD src1=3 held while frozen
        st(1, 2, 3, 1, 1, 0, 0, 1);
        st(3, 0, 8, 1, 0, 0, 0, 1);
        st(3, 0, 8, 1, 0, 0, 0, 1);
        st(3, 0, 8, 1, 0, 0, 0, 1);
        st(0, 0, 0, 0, 0, 0, 0, 1);
        st(0, 0, 0, 0, 0, 0, 0, 1);

        // ALU forward, adjacent then with an independent instruction between
        st(1, 2, 4, 1, 0, 0, 0, 1);
        st(1, 4, 9, 1, 0, 0, 0, 1);
        st(0, 0, 0, 0, 0, 0, 0, 1);
        st(0, 0, 0, 0, 0, 0, 0, 1);
        st(1, 2, 4, 1, 0, 0, 0, 1);
        st(1, 2, 10, 1, 0, 0, 0, 1);
        st(1, 4, 11, 1, 0, 0, 0, 1);
        st(0, 0, 0, 0, 0, 0, 0, 1);
        st(0, 0, 0, 0, 0, 0, 0, 1);

        // no-forward RAW: ADD r7 then OR src1=7 held
        st(1, 2, 7, 1, 0, 0, 0, 1);
        st(7, 0, 12, 1, 0, 0, 0, 1);
        st(7, 0, 12, 1, 0, 0, 0, 1);
        st(7, 0, 12, 1, 0, 0, 0, 1);
        st(7, 0, 12, 1, 0, 0, 0, 1);
        st(0, 0, 0, 0, 0, 0, 0, 1);

        // r0 producer and immediate consumer
        st(1, 2, 0, 1, 1, 0, 0, 1);
        st(0, 0, 13, 1, 0, 0, 0, 1);
        st(0, 0, 0, 0, 0, 0, 0, 1);
        st(0, 0, 0, 0, 0, 0, 0, 1);

        // branch coincident with load-use, then external stall
        st(1, 2, 9, 1, 1, 0, 0, 1);
        st(9, 0, 14, 1, 0, 1, 0, 1);
        st(1, 2, 15, 1, 1, 0, 0, 1);
        st(15, 15, 16, 1, 0, 0, 1, 1);
        st(15, 15, 16, 1, 0, 0, 1, 1);
        st(15, 15, 16, 1, 0, 0, 1, 1);
        st(15, 15, 16, 1, 0, 0, 0, 1);
        st(15, 15, 16, 1, 0, 0, 0, 1);
        st(0, 0, 0, 0, 0, 0, 0, 1);

        // randomized traffic, small register range for frequent matches
        for (int i = 0; i < 400; i++) begin
            st(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
               int'($urandom_range(0, 7)),
               $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
               $urandom_range(0, 9) == 0, $urandom_range(0, 6) == 0,
               $urandom_range(0, 39) != 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
